// File: rtl/draw_pkg.sv
// Shared command encodings, FSM states, screen geometry and origin lookups
// used by the draw scheduler and the game FSM that issues its commands.
package draw_pkg;

    localparam logic [1:0] CMD_CLEAR  = 2'd0;
    localparam logic [1:0] CMD_SCREEN = 2'd1;
    localparam logic [1:0] CMD_SPRITE = 2'd2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SCAN  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int SPRITE_W = 40;

    typedef struct packed {
        logic       valid;
        logic [7:0] x;
        logic [6:0] y;
        logic       black;
    } plot_t;

    // Sprite column slots: left group walks leftwards, right group rightwards.
    function automatic logic [7:0] x_origin(input logic [4:0] sel);
        logic [7:0] ox;
        case (sel)
            5'd1:    ox = 8'd36;
            5'd2:    ox = 8'd30;
            5'd3:    ox = 8'd24;
            5'd4:    ox = 8'd18;
            5'd5:    ox = 8'd12;
            5'd6:    ox = 8'd6;
            5'd8:    ox = 8'd90;
            5'd9:    ox = 8'd96;
            5'd10:   ox = 8'd102;
            5'd11:   ox = 8'd108;
            5'd12:   ox = 8'd114;
            5'd13:   ox = 8'd120;
            5'd14:   ox = 8'd84;
            5'd15:   ox = 8'd78;
            5'd16:   ox = 8'd72;
            5'd17:   ox = 8'd66;
            5'd18:   ox = 8'd60;
            5'd19:   ox = 8'd54;
            5'd20:   ox = 8'd48;
            5'd21:   ox = 8'd42;
            default: ox = 8'd0;
        endcase
        return ox;
    endfunction

    function automatic logic [6:0] y_origin(input logic [1:0] sel);
        return (sel == 2'd1) ? 7'd30 : 7'd0;
    endfunction

endpackage

// File: rtl/draw_plot_pipe.sv
// Delay line that keeps x/y/black/plot aligned with the image ROM read data.
// LAT=0 is a straight wire; flush squashes every in-flight entry.
module draw_plot_pipe
    import draw_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  flush,
    input  plot_t push,
    output plot_t head
);

    if (LAT == 0) begin : g_bypass
        assign head = push;
    end else begin : g_stages
        plot_t stage [LAT];

        always_ff @(posedge clk) begin
            if (reset || flush) begin
                for (int i = 0; i < LAT; i++) stage[i] <= '0;
            end else begin
                stage[0] <= push;
                for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
            end
        end

        assign head = stage[LAT-1];
    end

endmodule

// File: rtl/draw_scheduler.sv
// Walks one draw command's pixel rectangle, issuing ROM addresses and
// latency-aligned x/y/plot/black to the colour mux and VGA adapter.
//   state    | meaning
//   IDLE     | ready for a command
//   LOAD     | derive origin and extent from latched fields
//   SCAN     | one ROM address and one pipeline push per cycle
//   DRAIN    | wait ROM_LAT cycles for the last plot to emerge
//   DONE     | one-cycle done pulse
module draw_scheduler #(
    parameter int ROM_LAT  = 1,
    parameter int SCREEN_W = draw_pkg::SCREEN_W,
    parameter int SCREEN_H = draw_pkg::SCREEN_H,
    parameter int SPRITE_W = draw_pkg::SPRITE_W,
    parameter int ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [6:0]        cmd_mem_sel,
    input  logic [4:0]        cmd_x_sel,
    input  logic [1:0]        cmd_y_sel,
    input  logic              abort,
    output logic [7:0]        x,
    output logic [6:0]        y,
    output logic              plot,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [6:0]        mem_sel,
    output logic              black,
    output logic              busy,
    output logic              done
);
    import draw_pkg::plot_t, draw_pkg::x_origin, draw_pkg::y_origin;
    import draw_pkg::CMD_CLEAR, draw_pkg::CMD_SCREEN;
    import draw_pkg::ST_IDLE, draw_pkg::ST_LOAD, draw_pkg::ST_SCAN;
    import draw_pkg::ST_DRAIN, draw_pkg::ST_DONE;

    localparam logic [7:0] FULL_W_M1   = 8'(SCREEN_W - 1);
    localparam logic [6:0] FULL_H_M1   = 7'(SCREEN_H - 1);
    localparam logic [7:0] SPRITE_W_M1 = 8'(SPRITE_W - 1);
    localparam logic [6:0] SPRITE_H_M1 = 7'(SPRITE_W - 1);
    localparam logic [1:0] DRAIN_LOAD  = 2'((ROM_LAT > 0) ? ROM_LAT - 1 : 0);

    logic [2:0]        state;
    logic [1:0]        type_q;
    logic [4:0]        x_sel_q;
    logic [1:0]        y_sel_q;
    logic [7:0]        ox;
    logic [6:0]        oy;
    logic [7:0]        w_m1;
    logic [6:0]        h_m1;
    logic              black_q;
    logic [7:0]        cx;
    logic [6:0]        cy;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        drain_cnt;
    logic              is_full;
    logic              abort_eff;
    logic              scan_last;
    plot_t             pipe_in;
    plot_t             pipe_out;

    assign is_full   = (type_q == CMD_CLEAR) || (type_q == CMD_SCREEN);
    assign abort_eff = abort && ((state == ST_LOAD) || (state == ST_SCAN) || (state == ST_DRAIN));
    assign scan_last = (state == ST_SCAN) && (cx == w_m1) && (cy == h_m1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            type_q    <= '0;
            x_sel_q   <= '0;
            y_sel_q   <= '0;
            mem_sel   <= '0;
            ox        <= '0;
            oy        <= '0;
            w_m1      <= '0;
            h_m1      <= '0;
            black_q   <= 1'b0;
            cx        <= '0;
            cy        <= '0;
            addr      <= '0;
            drain_cnt <= '0;
        end else if (abort_eff) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        type_q  <= cmd_type;
                        x_sel_q <= cmd_x_sel;
                        y_sel_q <= cmd_y_sel;
                        mem_sel <= cmd_mem_sel;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    ox      <= is_full ? 8'd0 : x_origin(x_sel_q);
                    oy      <= is_full ? 7'd0 : y_origin(y_sel_q);
                    w_m1    <= is_full ? FULL_W_M1 : SPRITE_W_M1;
                    h_m1    <= is_full ? FULL_H_M1 : SPRITE_H_M1;
                    black_q <= (type_q == CMD_CLEAR);
                    cx      <= '0;
                    cy      <= '0;
                    addr    <= '0;
                    state   <= ST_SCAN;
                end
                ST_SCAN: begin
                    // rom_addr runs linearly, which equals cy*W+cx over a row-major scan
                    if (scan_last) begin
                        drain_cnt <= DRAIN_LOAD;
                        state     <= (ROM_LAT == 0) ? ST_DONE : ST_DRAIN;
                    end else begin
                        addr <= addr + ADDR_W'(1);
                        if (cx == w_m1) begin
                            cx <= '0;
                            cy <= cy + 7'd1;
                        end else begin
                            cx <= cx + 8'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == 2'd0) state <= ST_DONE;
                    else                   drain_cnt <= drain_cnt - 2'd1;
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pipe_in = '0;
        if (state == ST_SCAN) begin
            pipe_in.valid = 1'b1;
            pipe_in.x     = ox + cx;
            pipe_in.y     = oy + cy;
            pipe_in.black = black_q;
        end
    end

    draw_plot_pipe #(.LAT(ROM_LAT)) u_pipe (
        .clk   (clk),
        .reset (reset),
        .flush (abort_eff),
        .push  (pipe_in),
        .head  (pipe_out)
    );

    assign x         = pipe_out.x;
    assign y         = pipe_out.y;
    assign plot      = pipe_out.valid;
    assign black     = pipe_out.black;
    assign rom_addr  = addr;
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Sequences every pixel write to the VGA frame buffer: accepts one draw command at a time, scans the pixel rectangle and issues image-ROM addresses.
- Emits x/y/plot aligned with the ROM read latency, and selects the image via memory-select and black-override outputs that feed the colour mux.
- Sits between the game FSM (requester) and the colour mux / VGA adapter.
- Replaces ad hoc per-state loading of the x/y origin and scan registers.

Parameters:
- ROM_LAT, 1, ROM read latency in cycles (legal 0..3).
- SCREEN_W, 160, full-screen width in pixels.
- SCREEN_H, 120, full-screen height in pixels.
- SPRITE_W, 40, sprite tile edge (square).
- ADDR_W, 15, ROM address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; returns block to IDLE.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_type  in  2  0=CLEAR (black full screen), 1=SCREEN (full-screen image), 2=SPRITE (40x40 tile), 3=reserved (treated as SPRITE).
- cmd_mem_sel  in  7  image index for the colour mux.
- cmd_x_sel  in  5  sprite x-origin slot code.
- cmd_y_sel  in  2  sprite y-origin code.
- abort  in  1  cancel current draw.
- x  out  8  pixel x, aligned with plot.
- y  out  7  pixel y, aligned with plot.
- plot  out  1  write-enable to the VGA adapter.
- rom_addr  out  ADDR_W  image ROM address.
- mem_sel  out  7  registered image index.
- black  out  1  colour override, aligned with plot.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse after the last plot.

Behaviour:
- Reset values: state=IDLE, cmd_ready=1, x=0, y=0, plot=0, rom_addr=0, mem_sel=0, black=0, busy=0, done=0. The plot pipeline is cleared.
- Acceptance: a command is accepted when cmd_valid && cmd_ready, in cycle T0. Fields are latched and mem_sel is updated at T0. mem_sel holds until the next acceptance.
- States and transitions:
  - IDLE -> LOAD on acceptance.
  - LOAD (1 cycle): compute origin (ox, oy) and extent; reset scan counters cx=cy=0.
  - LOAD -> SCAN.
  - SCAN: each cycle, issue rom_addr = cy*W + cx, where W=SCREEN_W for CLEAR/SCREEN and SPRITE_W for SPRITE. Push (ox+cx, oy+cy, black_flag) into a ROM_LAT-deep valid pipeline. cx increments; on cx=W-1, cx wraps to 0 and cy increments.
  - SCAN -> DRAIN after issuing the last pixel (cx=W-1, cy=H-1).
  - DRAIN: ROM_LAT cycles (0 cycles when ROM_LAT=0).
  - DRAIN -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Timing: first address in cycle T0+2; first plot in cycle T0+2+ROM_LAT. Exactly W*H plots, contiguous, with no gaps.
- Origins:
  - CLEAR/SCREEN: origin (0,0), extent 160x120, 19200 plots. Last rom_addr = 19199.
  - SPRITE: extent 40x40, 1600 plots, rom_addr 0..1599.
  - x origin from cmd_x_sel: 1..7 -> 36,30,24,18,12,6,0; 8..13 -> 90,96,102,108,114,120; 14..21 -> 84,78,72,66,60,54,48,42; 0 and 22..31 -> 0.
  - y origin from cmd_y_sel: 1 -> 30; all other codes -> 0.
- black=1 on every plot of a CLEAR command; 0 otherwise. rom_addr is still generated for CLEAR.
- Arithmetic: coordinates are computed at full width, then truncated to 8/7 bits. All legal origins fit the screen (max x 159, max y 69); no clipping.
- abort:
  - In LOAD/SCAN/DRAIN: next state IDLE, in-flight pipeline entries squashed (plot=0 from the next cycle), no done pulse.
  - In IDLE/DONE: ignored. A done already in progress still pulses.
  - abort and cmd_valid in the same IDLE cycle: the command is accepted.
- cmd_valid while busy is ignored (not queued).
- reset mid-draw: same as the reset values above, in the cycle after reset is sampled.

Decomposition:
- Shared package draw_pkg holds:
  - cmd_type encodings (CMD_CLEAR, CMD_SCREEN, CMD_SPRITE).
  - state encoding.
  - SCREEN_W/H, SPRITE_W constants.
  - x-slot and y-code origin lookup functions (shared with the game FSM).
- One sub-module, draw_plot_pipe: a ROM_LAT-deep valid/x/y/black shift pipeline with synchronous flush.

Test Plan:
- Reset, then SPRITE with x_sel=8, y_sel=1, mem_sel=10, ROM_LAT=1:
  - First plot at T0+3 with x=90, y=30, rom_addr=0 issued at T0+2.
  - 1600 plots, last x=129, y=69.
  - done at the cycle after the last plot; mem_sel=10 throughout.
- CLEAR: 19200 plots, black=1 on all of them; last (x,y) = (159,119); cmd_ready=0 until the cycle after done.
- SCREEN with ROM_LAT=0 and ROM_LAT=3: first plot at T0+2 and T0+5 respectively; plot count 19200; rom_addr sequence 0..19199 with no gaps.
- Abort in SCAN after 100 addresses: plot=0 from the next cycle, no done, cmd_ready=1 in the next cycle. Then a new SPRITE command completes normally.
- cmd_valid held during a draw with different fields: ignored; fields sampled only at acceptance; back-to-back commands are accepted only in IDLE.
- x_sel=22, y_sel=3: origin (0,0). Reset asserted mid-DRAIN: all outputs at reset values in the next cycle, no done.
